// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D cache line-memory arbiter: FSM encoding,
// default widths and requester indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    localparam int REQ_I = 0;
    localparam int REQ_D = 1;

    // A requester doing read and write together is served as a write.
    function automatic logic eff_read(input logic rd, input logic wr);
        return rd & ~wr;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker. On a tie the side that was not served
// last wins; the last-served state is kept by the caller.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // one-hot grant selection
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b11:   grant = last ? 2'b01 : 2'b10;
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single line-memory port between the I-cache and the D-cache,
// one registered transaction at a time, with round-robin on ties.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIRST_PRIO = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              grant_d
);

    // last_srv = 1 means the D-cache was served last; starting "I served"
    // makes D win the first tie when FIRST_PRIO selects D.
    localparam logic LAST_RST = (FIRST_PRIO == 1) ? 1'b0 : 1'b1;

    arb_state_t        state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              grant_d_q, grant_d_d;
    logic              last_srv_q, last_srv_d;

    logic [1:0]        req_s;
    logic [1:0]        arb_grant_s;

    assign req_s[REQ_I] = i_read | i_write;
    assign req_s[REQ_D] = d_read | d_write;

    rr_arb2 u_rr_arb2 (
        .req   (req_s),
        .last  (last_srv_q),
        .grant (arb_grant_s)
    );

    // next-state and next mem_* register values
    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_d_d   = grant_d_q;
        last_srv_d  = last_srv_q;
        case (state_q)
            IDLE: begin
                if (arb_grant_s[REQ_D]) begin
                    state_d     = BUSY_D;
                    mem_read_d  = eff_read(d_read, d_write);
                    mem_write_d = d_write;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    grant_d_d   = 1'b1;
                end else if (arb_grant_s[REQ_I]) begin
                    state_d     = BUSY_I;
                    mem_read_d  = eff_read(i_read, i_write);
                    mem_write_d = i_write;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = i_wdata;
                    grant_d_d   = 1'b0;
                end else begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    last_srv_d  = 1'b0;
                end else begin
                    state_d = BUSY_I;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    last_srv_d  = 1'b1;
                end else begin
                    state_d = BUSY_D;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // state and memory-side registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            grant_d_q   <= 1'b0;
            last_srv_q  <= LAST_RST;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            grant_d_q   <= grant_d_d;
            last_srv_q  <= last_srv_d;
        end
    end

    // completion and read data pass straight through to the owner only
    always_comb begin
        i_ready = 1'b0;
        d_ready = 1'b0;
        i_rdata = '0;
        d_rdata = '0;
        if (state_q == BUSY_I) begin
            i_ready = mem_ready;
            i_rdata = mem_rdata;
        end else if (state_q == BUSY_D) begin
            d_ready = mem_ready;
            d_rdata = mem_rdata;
        end else begin
            i_ready = 1'b0;
            d_ready = 1'b0;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant_d   = grant_d_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants and completions are queued
// by the stimulus and checked by independent monitors.
module tb_mem_arbiter;

    logic         clk;
    logic         rst_n;
    logic         i_read, i_write, d_read, d_write;
    logic [27:0]  i_addr, d_addr, mem_addr;
    logic [127:0] i_wdata, d_wdata, i_rdata, d_rdata;
    logic         i_ready, d_ready;
    logic         mem_read, mem_write, mem_ready, grant_d;
    logic [127:0] mem_wdata, mem_rdata;

    typedef struct packed {
        logic         gd;
        logic         rd;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
    } gexp_t;

    typedef struct packed {
        logic         side;
        logic [127:0] rdata;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t mon_g;
    rexp_t mon_r;
    logic        strobe_prev;
    logic [27:0] held_addr;

    int n_tests;
    int n_fail;

    localparam logic [127:0] RD_A5 = {16{8'hA5}};
    localparam logic [127:0] DW_20 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] IW_30 = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;

    mem_arbiter #(.ADDR_W(28), .DATA_W(128), .FIRST_PRIO(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_read    (i_read),
        .i_write   (i_write),
        .i_addr    (i_addr),
        .i_wdata   (i_wdata),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .grant_d   (grant_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // grant monitor: a new strobe opens a transaction that must match the queue
    initial strobe_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n && (mem_read || mem_write) && !strobe_prev) begin
            if (gq.size() == 0) begin
                check("unexpected_grant", 128'd1, 128'd0);
            end else begin
                mon_g = gq.pop_front();
                check("grant_d",   128'(grant_d),   128'(mon_g.gd));
                check("mem_read",  128'(mem_read),  128'(mon_g.rd));
                check("mem_write", 128'(mem_write), 128'(mon_g.wr));
                check("mem_addr",  128'(mem_addr),  128'(mon_g.addr));
                check("mem_wdata", mem_wdata,       mon_g.wdata);
                held_addr = mem_addr;
            end
        end else if ((mem_read || mem_write) && strobe_prev) begin
            check("mem_addr_held", 128'(mem_addr), 128'(held_addr));
        end
        strobe_prev = mem_read | mem_write;
    end

    // completion monitor
    always @(negedge clk) begin
        if (i_ready || d_ready) begin
            if (rq.size() == 0) begin
                check("unexpected_ready", 128'd1, 128'd0);
            end else begin
                mon_r = rq.pop_front();
                check("ready_side", 128'(d_ready), 128'(mon_r.side));
                check("ready_excl", 128'(i_ready & d_ready), 128'd0);
                check("rdata", mon_r.side ? d_rdata : i_rdata, mon_r.rdata);
                check("other_rdata", mon_r.side ? i_rdata : d_rdata, 128'd0);
            end
        end
    end

    task automatic wait_strobe(output int n);
        n = 0;
        while (!(mem_read || mem_write) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // expects a strobe one edge after entry, answers after lat more cycles
    task automatic serve(input logic side, input int lat, input logic [127:0] rdata, input bit chg_d);
        int n;
        wait_strobe(n);
        check("strobe_latency", 128'(n), 128'd1);
        if (n < 20) begin
            if (chg_d) begin
                d_addr  = d_addr + 28'h10;
                d_wdata = ~d_wdata;
            end
            repeat (lat) begin
                @(posedge clk);
                #1;
            end
            rq.push_back('{side, rdata});
            mem_rdata = rdata;
            mem_ready = 1'b1;
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
        end
    endtask

    initial begin
        int n;
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0;
        i_read = 1'b0; i_write = 1'b0; i_addr = 28'h0; i_wdata = 128'd0;
        d_read = 1'b0; d_write = 1'b0; d_addr = 28'h0; d_wdata = 128'd0;
        mem_rdata = 128'd0; mem_ready = 1'b0;
        #2;
        check("rst_mem_read",  128'(mem_read),  128'd0);
        check("rst_mem_write", 128'(mem_write), 128'd0);
        check("rst_mem_addr",  128'(mem_addr),  128'd0);
        check("rst_mem_wdata", mem_wdata,       128'd0);
        check("rst_grant_d",   128'(grant_d),   128'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single I read
        i_addr = 28'h0000010;
        gq.push_back('{1'b0, 1'b1, 1'b0, 28'h0000010, 128'd0});
        i_read = 1'b1;
        serve(1'b0, 3, RD_A5, 1'b0);
        i_read = 1'b0;

        // simultaneous: D wins first tie, I follows after re-arbitration
        d_addr = 28'h20; d_wdata = DW_20; d_write = 1'b1;
        i_addr = 28'h30; i_wdata = IW_30; i_read = 1'b1;
        gq.push_back('{1'b1, 1'b0, 1'b1, 28'h20, DW_20});
        gq.push_back('{1'b0, 1'b1, 1'b0, 28'h30, IW_30});
        serve(1'b1, 2, 128'h0BAD_F00D, 1'b0);
        d_write = 1'b0;
        serve(1'b0, 2, 128'hC0DE_0030, 1'b0);
        i_read = 1'b0;

        // fairness under continuous requests from both sides
        d_addr = 28'h100; d_wdata = 128'hD1;
        i_addr = 28'h200; i_wdata = 128'h11;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) gq.push_back('{1'b1, 1'b1, 1'b0, 28'h100, 128'hD1});
            else            gq.push_back('{1'b0, 1'b1, 1'b0, 28'h200, 128'h11});
        end
        d_read = 1'b1; i_read = 1'b1;
        for (int k = 0; k < 6; k++) begin
            serve((k % 2) == 0, 1, 128'(k + 100), 1'b0);
        end
        d_read = 1'b0; i_read = 1'b0;

        // requester inputs change while busy
        d_addr = 28'h40; d_wdata = 128'h4040;
        gq.push_back('{1'b1, 1'b1, 1'b0, 28'h40, 128'h4040});
        d_read = 1'b1;
        serve(1'b1, 3, 128'h4444, 1'b1);
        d_read = 1'b0;

        // spurious mem_ready in IDLE
        mem_rdata = RD_A5;
        mem_ready = 1'b1;
        @(negedge clk);
        check("spur_i_ready", 128'(i_ready), 128'd0);
        check("spur_d_ready", 128'(d_ready), 128'd0);
        check("spur_i_rdata", i_rdata, 128'd0);
        check("spur_d_rdata", d_rdata, 128'd0);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        check("spur_strobes", 128'({mem_read, mem_write}), 128'd0);
        check("spur_grant_hold", 128'(grant_d), 128'd1);

        // read and write together is a write
        i_addr = 28'h60; i_wdata = 128'h6666;
        gq.push_back('{1'b0, 1'b0, 1'b1, 28'h60, 128'h6666});
        i_read = 1'b1; i_write = 1'b1;
        serve(1'b0, 2, 128'h0606, 1'b0);
        i_read = 1'b0; i_write = 1'b0;

        // async reset in the middle of an I transaction
        i_addr = 28'h70; i_wdata = 128'h7070;
        gq.push_back('{1'b0, 1'b1, 1'b0, 28'h70, 128'h7070});
        i_read = 1'b1;
        wait_strobe(n);
        check("busy_i_latency", 128'(n), 128'd1);
        d_addr = 28'h80; d_wdata = 128'h8080; d_read = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_async_mem_read", 128'(mem_read), 128'd0);
        check("rst_async_grant_d",  128'(grant_d),  128'd0);
        check("rst_async_i_ready",  128'(i_ready),  128'd0);
        gq.push_back('{1'b1, 1'b1, 1'b0, 28'h80, 128'h8080});
        gq.push_back('{1'b0, 1'b1, 1'b0, 28'h70, 128'h7070});
        @(negedge clk);
        #2 rst_n = 1'b1;
        serve(1'b1, 2, 128'h8888, 1'b0);
        d_read = 1'b0;
        serve(1'b0, 2, 128'h7777, 1'b0);
        i_read = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("grants_drained", 128'(gq.size()), 128'd0);
        check("readies_drained", 128'(rq.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one slow line-memory port between the instruction cache and the data cache.
- Sits between the two cache memory-side interfaces and the external memory.
- Grants one cache at a time, registers and forwards its request, and routes read data and ready back to that cache.
- Round-robin arbitration on simultaneous requests prevents starvation.

Parameters:
- ADDR_W, 28, line address width (byte address bits [31:4]).
- DATA_W, 128, line data width.
- FIRST_PRIO, 1, requester favoured on the first tie after reset (1 = D-cache, 0 = I-cache).

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  I-cache line read request (level, held until i_ready)
- i_write  in  1  I-cache line write request (level)
- i_addr  in  ADDR_W  I-cache line address
- i_wdata  in  DATA_W  I-cache write line
- i_rdata  out  DATA_W  read line to I-cache
- i_ready  out  1  completion pulse to I-cache
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ready  same as the i_* group, for the D-cache
- mem_read  out  1  memory read strobe (registered)
- mem_write  out  1  memory write strobe (registered)
- mem_addr  out  ADDR_W  registered line address
- mem_wdata  out  DATA_W  registered write line
- mem_rdata  in  DATA_W  memory read line
- mem_ready  in  1  memory completion pulse
- grant_d  out  1  current owner (1 = D, 0 = I); valid while busy

Behaviour:
- Reset (asynchronous, immediate): state IDLE; mem_read, mem_write, mem_addr, mem_wdata = 0; grant_d = 0; last-served pointer set to the opposite of FIRST_PRIO.
- Reset mid-transaction aborts it; no ready is produced.
- The FSM has three states, with these transitions:
- IDLE: request(x) = x_read | x_write.
  - Only one side requesting: grant it.
  - Both requesting: grant the side not served last.
  - On grant, latch addr, wdata, and read/write into the mem_* registers; next state BUSY_I or BUSY_D.
  - No request: stay in IDLE with mem strobes 0.
- BUSY_x: hold mem_* constant, ignoring changes on the requester inputs.
  - On mem_ready = 1: x_ready = 1 in that same cycle (combinational pass-through).
  - Clear mem_read and mem_write at the clock edge.
  - Update last-served to x; next state IDLE.
- Latency: request first seen in IDLE at cycle t gives mem strobe at t+1.
  - mem_ready at t+k gives x_ready at t+k.
  - Earliest next grant (either side) is seen in IDLE at t+k+1, with its strobe at t+k+2.
  - A cache issuing back-to-back requests (write-back then allocate) is therefore re-arbitrated; the other side wins a tie.
- x_rdata = mem_rdata while BUSY_x, else 0. The non-granted side's ready is always 0.
- mem_ready outside BUSY is ignored (no ready pulse, no state change).
- Both read and write asserted by one requester: treated as a write; mem_read = 0.
- Requests are not queued. A requester dropping its request while the other is busy is simply not granted.
- grant_d is updated with the state; it holds its last value in IDLE.

Decomposition:
- Shared package mem_arb_pkg holds:
  - FSM state encoding (IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2);
  - ADDR_W and DATA_W defaults;
  - requester index constants (REQ_I = 0, REQ_D = 1).
- One sub-module, rr_arb2: a two-requester round-robin picker (req[1:0], last, grant one-hot). It is purely combinational; the last-served register lives in mem_arbiter.

Test Plan:
- Single I read: i_read = 1, i_addr = 0x0000010, mem_ready after 4 cycles with mem_rdata = 0xA5.. → mem_read = 1 and mem_addr = 0x0000010 from t+1; i_ready = 1 and i_rdata = 0xA5.. at t+4; d_ready = 0 throughout.
- Simultaneous requests after reset (FIRST_PRIO = 1): d_write = 1 addr 0x20, i_read = 1 addr 0x30 → D served first (mem_write = 1, mem_wdata = d_wdata), then I (mem_read, addr 0x30) strobed two cycles after d_ready.
- Fairness: both sides request continuously for 6 transactions → grants alternate D, I, D, I, D, I; no side is granted twice consecutively.
- Input change while busy: during BUSY_D, d_addr changes 0x40→0x50 → mem_addr stays 0x40 until mem_ready.
- Spurious mem_ready in IDLE → no x_ready, state stays IDLE. Read and write asserted together → mem_write = 1, mem_read = 0.
- Asynchronous reset asserted in BUSY_I mid-wait → mem_read = 0 immediately; after release, a pending d_read is granted (D favoured) with mem strobe one cycle later.
